width_16to8: RTL and testbench

Width down-converter that splits each accepted 16-bit word into two 8-bit beats on a byte-wide stream, with valid/ready handshakes on both sides. It is the transmit-side counterpart of the 8-to-16 packer. It sits between a 16-bit producer and a byte-serial consumer. A one-word pending buffer lets it sustain one byte per cycle under continuous flow.

---
 rtl/width_16to8_if.sv | 31 +++
 rtl/width_16to8.sv | 85 ++++++++
 tb/tb_width_16to8.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/width_16to8_if.sv
// Handshake bundle for the 16-to-8 width down-converter: 16-bit word side in, byte side out.
// The slave modport is the converter's view; master is the producer/consumer harness view.
interface width_16to8_if;
   logic        valid_in;
   logic        ready_in;
   logic [15:0] data_in;
   logic        valid_out;
   logic        ready_out;
   logic [7:0]  data_out;
   logic        last_out;

   modport slave (
      input  valid_in,
      input  data_in,
      input  ready_out,
      output ready_in,
      output valid_out,
      output data_out,
      output last_out
   );

   modport master (
      output valid_in,
      output data_in,
      output ready_out,
      input  ready_in,
      input  valid_out,
      input  data_out,
      input  last_out
   );
endinterface

// File: rtl/width_16to8.sv
// Splits each accepted 16-bit word into two bytes; a one-word pending buffer sustains one byte
// per cycle under continuous flow. All outputs come straight from registers.
module width_16to8 #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   width_16to8_if.slave  bus
);

   logic [15:0] cur_word_q, cur_word_d;
   logic        cur_valid_q, cur_valid_d;
   logic        phase_q, phase_d;
   logic [15:0] pend_word_q, pend_word_d;
   logic        pend_valid_q, pend_valid_d;

   logic        xfer;
   logic        accept;
   logic        last_xfer;
   logic [7:0]  first_byte;
   logic [7:0]  second_byte;

   assign xfer      = cur_valid_q && bus.ready_out;
   assign accept    = bus.valid_in && !pend_valid_q;
   assign last_xfer = xfer && phase_q;

   assign first_byte  = MSB_FIRST ? cur_word_q[15:8] : cur_word_q[7:0];
   assign second_byte = MSB_FIRST ? cur_word_q[7:0]  : cur_word_q[15:8];

   assign bus.valid_out = cur_valid_q;
   assign bus.last_out  = cur_valid_q && phase_q;
   assign bus.data_out  = !cur_valid_q ? 8'h00 : (phase_q ? second_byte : first_byte);
   assign bus.ready_in  = !pend_valid_q;

   always_comb begin
      cur_word_d   = cur_word_q;
      cur_valid_d  = cur_valid_q;
      phase_d      = phase_q;
      pend_word_d  = pend_word_q;
      pend_valid_d = pend_valid_q;

      if (xfer && !phase_q) begin
         phase_d = 1'b1;
      end else if (last_xfer) begin
         phase_d = 1'b0;
         if (pend_valid_q) begin
            cur_word_d   = pend_word_q;
            pend_valid_d = 1'b0;
         end else if (accept) begin
            // Refill cur directly so the next word follows with no bubble.
            cur_word_d = bus.data_in;
         end else begin
            cur_valid_d = 1'b0;
         end
      end

      if (accept && !last_xfer) begin
         if (!cur_valid_q) begin
            cur_word_d  = bus.data_in;
            cur_valid_d = 1'b1;
            phase_d     = 1'b0;
         end else begin
            pend_word_d  = bus.data_in;
            pend_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_word_q   <= 16'h0;
         cur_valid_q  <= 1'b0;
         phase_q      <= 1'b0;
         pend_word_q  <= 16'h0;
         pend_valid_q <= 1'b0;
      end else begin
         cur_word_q   <= cur_word_d;
         cur_valid_q  <= cur_valid_d;
         phase_q      <= phase_d;
         pend_word_q  <= pend_word_d;
         pend_valid_q <= pend_valid_d;
      end
   end

endmodule

// File: tb/tb_width_16to8.sv
// Directed bench for width_16to8: reset, single word, streaming, backpressure, LSB-first order
// and asynchronous reset mid-word. Inputs change and outputs are sampled 1ns after posedge.
module tb_width_16to8;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   width_16to8_if bus ();
   width_16to8_if bus_l ();

   width_16to8 #(.MSB_FIRST(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   width_16to8 #(.MSB_FIRST(1'b0)) dut_l (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_l)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.valid_in    = 1'b0;
      bus.data_in     = 16'h0;
      bus.ready_out   = 1'b0;
      bus_l.valid_in  = 1'b0;
      bus_l.data_in   = 16'h0;
      bus_l.ready_out = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) step();
      for (int k = 0; k < 2; k++) begin
         n_vec++;
         if (bus.valid_out !== 1'b0) begin
            n_err++; $display("FAIL reset_valid_out[%0d]: got %b want 0", k, bus.valid_out);
         end
         n_vec++;
         if (bus.data_out !== 8'h00) begin
            n_err++; $display("FAIL reset_data_out[%0d]: got %h want 00", k, bus.data_out);
         end
         n_vec++;
         if (bus.last_out !== 1'b0) begin
            n_err++; $display("FAIL reset_last_out[%0d]: got %b want 0", k, bus.last_out);
         end
         n_vec++;
         if (bus.ready_in !== 1'b1) begin
            n_err++; $display("FAIL reset_ready_in[%0d]: got %b want 1", k, bus.ready_in);
         end
         rst_n = 1'b1;
         repeat (2) step();
      end
   endtask

   task automatic test_single();
      do_reset();
      bus.ready_out = 1'b1;
      bus.valid_in  = 1'b1;
      bus.data_in   = 16'hA55A;
      step();
      bus.valid_in = 1'b0;
      n_vec++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hA5 || bus.last_out !== 1'b0) begin
         n_err++;
         $display("FAIL single_first: got v=%b d=%h l=%b want v=1 d=a5 l=0",
                  bus.valid_out, bus.data_out, bus.last_out);
      end
      step();
      n_vec++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h5A || bus.last_out !== 1'b1) begin
         n_err++;
         $display("FAIL single_second: got v=%b d=%h l=%b want v=1 d=5a l=1",
                  bus.valid_out, bus.data_out, bus.last_out);
      end
      step();
      n_vec++;
      if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h00) begin
         n_err++;
         $display("FAIL single_drain: got v=%b d=%h want v=0 d=00", bus.valid_out, bus.data_out);
      end
   endtask

   task automatic test_stream();
      logic [15:0] words [3];
      logic [7:0]  exp_b [6];
      logic        exp_r [6];
      int          wi;
      int          bi;
      logic        acc;
      words = '{16'h1234, 16'h5678, 16'h9ABC};
      exp_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
      exp_r = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      bus.ready_out = 1'b1;
      wi = 0;
      bi = 0;
      for (int cyc = 0; cyc < 20 && bi < 6; cyc++) begin
         if (cyc < 6) begin
            n_vec++;
            if (bus.ready_in !== exp_r[cyc]) begin
               n_err++;
               $display("FAIL stream_ready_in[%0d]: got %b want %b", cyc, bus.ready_in, exp_r[cyc]);
            end
         end
         if (cyc >= 1) begin
            n_vec++;
            if (bus.valid_out !== 1'b1) begin
               n_err++; $display("FAIL stream_gap[%0d]: got valid_out=%b want 1", cyc, bus.valid_out);
            end
         end
         if (bus.valid_out === 1'b1) begin
            n_vec++;
            if (bus.data_out !== exp_b[bi] || bus.last_out !== bi[0]) begin
               n_err++;
               $display("FAIL stream_byte[%0d]: got d=%h l=%b want d=%h l=%b",
                        bi, bus.data_out, bus.last_out, exp_b[bi], bi[0]);
            end
            bi++;
         end
         bus.valid_in = (wi < 3);
         bus.data_in  = (wi < 3) ? words[wi] : 16'h0;
         acc = bus.valid_in && bus.ready_in;
         step();
         if (acc) wi++;
      end
      bus.valid_in = 1'b0;
      n_vec++;
      if (bi != 6) begin
         n_err++; $display("FAIL stream_timeout: got %0d bytes want 6", bi);
      end
      n_vec++;
      if (bus.valid_out !== 1'b0) begin
         n_err++; $display("FAIL stream_drain: got valid_out=%b want 0", bus.valid_out);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_b [6];
      int         wi;
      int         bi;
      logic       acc;
      exp_b = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h11, 8'h11};
      do_reset();
      bus.ready_out = 1'b0;
      bus.valid_in  = 1'b1;
      bus.data_in   = 16'hCAFE;
      step();
      bus.data_in = 16'hF00D;
      step();
      bus.data_in = 16'h1111;
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (bus.ready_in !== 1'b0) begin
            n_err++; $display("FAIL bp_ready_in[%0d]: got %b want 0", k, bus.ready_in);
         end
         n_vec++;
         if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hCA || bus.last_out !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: got v=%b d=%h l=%b want v=1 d=ca l=0",
                     k, bus.valid_out, bus.data_out, bus.last_out);
         end
         step();
      end
      bus.ready_out = 1'b1;
      wi = 0;
      bi = 0;
      for (int cyc = 0; cyc < 20 && bi < 6; cyc++) begin
         n_vec++;
         if (bus.valid_out !== 1'b1) begin
            n_err++; $display("FAIL bp_gap[%0d]: got valid_out=%b want 1", cyc, bus.valid_out);
         end
         if (bus.valid_out === 1'b1) begin
            n_vec++;
            if (bus.data_out !== exp_b[bi] || bus.last_out !== bi[0]) begin
               n_err++;
               $display("FAIL bp_byte[%0d]: got d=%h l=%b want d=%h l=%b",
                        bi, bus.data_out, bus.last_out, exp_b[bi], bi[0]);
            end
            bi++;
         end
         bus.valid_in = (wi < 1);
         acc = bus.valid_in && bus.ready_in;
         step();
         if (acc) wi++;
      end
      bus.valid_in = 1'b0;
      n_vec++;
      if (bi != 6 || wi != 1) begin
         n_err++; $display("FAIL bp_timeout: got bytes=%0d words=%0d want 6 and 1", bi, wi);
      end
      n_vec++;
      if (bus.valid_out !== 1'b0) begin
         n_err++; $display("FAIL bp_drain: got valid_out=%b want 0", bus.valid_out);
      end
   endtask

   task automatic test_lsb_first();
      do_reset();
      bus_l.ready_out = 1'b1;
      bus_l.valid_in  = 1'b1;
      bus_l.data_in   = 16'hBEEF;
      step();
      bus_l.valid_in = 1'b0;
      n_vec++;
      if (bus_l.valid_out !== 1'b1 || bus_l.data_out !== 8'hEF || bus_l.last_out !== 1'b0) begin
         n_err++;
         $display("FAIL lsb_first: got v=%b d=%h l=%b want v=1 d=ef l=0",
                  bus_l.valid_out, bus_l.data_out, bus_l.last_out);
      end
      step();
      n_vec++;
      if (bus_l.valid_out !== 1'b1 || bus_l.data_out !== 8'hBE || bus_l.last_out !== 1'b1) begin
         n_err++;
         $display("FAIL lsb_second: got v=%b d=%h l=%b want v=1 d=be l=1",
                  bus_l.valid_out, bus_l.data_out, bus_l.last_out);
      end
      step();
      n_vec++;
      if (bus_l.valid_out !== 1'b0) begin
         n_err++; $display("FAIL lsb_drain: got valid_out=%b want 0", bus_l.valid_out);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.ready_out = 1'b1;
      bus.valid_in  = 1'b1;
      bus.data_in   = 16'h1234;
      step();
      bus.data_in = 16'h5678;
      step();
      bus.valid_in = 1'b0;
      n_vec++;
      if (bus.data_out !== 8'h34 || bus.ready_in !== 1'b0) begin
         n_err++;
         $display("FAIL mid_setup: got d=%h rdy=%b want d=34 rdy=0", bus.data_out, bus.ready_in);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h00 || bus.last_out !== 1'b0 ||
          bus.ready_in !== 1'b1) begin
         n_err++;
         $display("FAIL mid_async: got v=%b d=%h l=%b rdy=%b want v=0 d=00 l=0 rdy=1",
                  bus.valid_out, bus.data_out, bus.last_out, bus.ready_in);
      end
      step();
      rst_n = 1'b1;
      step();
      n_vec++;
      if (bus.valid_out !== 1'b0) begin
         n_err++; $display("FAIL mid_release: got valid_out=%b want 0", bus.valid_out);
      end
      bus.valid_in = 1'b1;
      bus.data_in  = 16'h00FF;
      step();
      bus.valid_in = 1'b0;
      n_vec++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h00 || bus.last_out !== 1'b0) begin
         n_err++;
         $display("FAIL mid_next_first: got v=%b d=%h l=%b want v=1 d=00 l=0",
                  bus.valid_out, bus.data_out, bus.last_out);
      end
      step();
      n_vec++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hFF || bus.last_out !== 1'b1) begin
         n_err++;
         $display("FAIL mid_next_second: got v=%b d=%h l=%b want v=1 d=ff l=1",
                  bus.valid_out, bus.data_out, bus.last_out);
      end
      step();
      n_vec++;
      if (bus.valid_out !== 1'b0) begin
         n_err++; $display("FAIL mid_stale: got valid_out=%b want 0", bus.valid_out);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_lsb_first();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
